// File: rtl/orbus_resp_pkg.sv
// ---------------------------------------------------------------------------
// orbus_resp_pkg
// Shared encodings for the OR-bus responder: FSM states, register address map
// and a byte-lane merge helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package orbus_resp_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RDATA = 2'd2,
    ST_WACK  = 2'd3
  } state_t;

  // Register map within the responder window
  localparam int          NUM_RW_REGS = 6;
  localparam logic [2:0]  REG_STAT    = 3'd6;
  localparam logic [2:0]  REG_ID      = 3'd7;

  // Merge write data into an existing word, one byte lane per enable bit
  function automatic logic [15:0] merge_bytes(input logic [15:0] old_val,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  be);
    logic [15:0] res;
    res       = old_val;
    if (be[0]) res[7:0]  = wdata[7:0];
    if (be[1]) res[15:8] = wdata[15:8];
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/orbus_resp_regs.sv
// ---------------------------------------------------------------------------
// orbus_resp_regs
// Register file of the responder: six read/write words, a sticky event status
// word with read-to-clear, and a constant identification word.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module orbus_resp_regs
  import orbus_resp_pkg::*;
#(
  parameter logic [15:0] ID_VAL = 16'h0A51
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_be,
  input  logic [15:0] evt,
  input  logic [2:0]  rd_addr,
  input  logic        rd_capture,
  output logic [15:0] rd_data
);

  logic [15:0] regs [NUM_RW_REGS];
  logic [15:0] stat;
  logic [15:0] clr_mask;

  // Byte-enabled writes to the plain registers; addresses 6 and 7 never match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        if (wr_en && (wr_addr == 3'(i))) begin
          regs[i] <= merge_bytes(regs[i], wr_data, wr_be);
        end
      end
    end
  end

  // Clear only the bits being returned to the bus on the capture edge
  always_comb begin
    clr_mask = '0;
    if (rd_capture && (rd_addr == REG_STAT)) begin
      clr_mask = stat;
    end
  end

  // Sticky status: new events are OR-ed in after the clear so a set wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat <= '0;
    end else begin
      stat <= (stat & ~clr_mask) | evt;
    end
  end

  // Read mux over the whole window
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_STAT: rd_data = stat;
      REG_ID:   rd_data = ID_VAL;
      default: begin
        for (int i = 0; i < NUM_RW_REGS; i++) begin
          if (rd_addr == 3'(i)) begin
            rd_data = regs[i];
          end
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/orbus_resp.sv
// ---------------------------------------------------------------------------
// orbus_resp
// OR-bus responder: accepts read/write strobes in its window, inserts
// WAIT_CYC read wait states, drives MDR only during the read data cycle and
// pulses ACK for one cycle at the end of every access.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module orbus_resp
  import orbus_resp_pkg::*;
#(
  parameter int          WAIT_CYC = 1,
  parameter logic [15:0] ID_VAL   = 16'h0A51
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CSEL,
  input  logic        RD,
  input  logic        WR,
  input  logic [2:0]  MA,
  input  logic [15:0] MDW,
  input  logic [1:0]  WBE,
  input  logic [15:0] EVT,
  output logic [15:0] MDR,
  output logic        BUSY,
  output logic        ACK
);

  // Zero wait states skip the WAIT state entirely
  localparam logic       NO_WAIT  = (WAIT_CYC == 0);
  localparam logic [1:0] CNT_LOAD = (WAIT_CYC > 0) ? 2'(WAIT_CYC - 1) : 2'd0;

  state_t      state;
  logic [1:0]  cnt;
  logic [2:0]  addr_q;
  logic [15:0] mdr_q;
  logic        busy_q;
  logic        ack_q;

  logic        rd_req;
  logic        wr_req;
  logic        capture;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;

  // Strobe qualification and the edge on which read data is sampled
  always_comb begin
    rd_req  = (state == ST_IDLE) && CSEL && RD;
    wr_req  = (state == ST_IDLE) && CSEL && WR && !RD;
    capture = (rd_req && NO_WAIT) || ((state == ST_WAIT) && (cnt == 2'd0));
    // With no wait states the capture happens on the strobe edge itself,
    // before the address has been latched
    rd_addr = (state == ST_IDLE) ? MA : addr_q;
  end

  orbus_resp_regs #(
    .ID_VAL (ID_VAL)
  ) u_regs (
    .clk        (CLK),
    .rst        (RESET),
    .wr_en      (wr_req),
    .wr_addr    (MA),
    .wr_data    (MDW),
    .wr_be      (WBE),
    .evt        (EVT),
    .rd_addr    (rd_addr),
    .rd_capture (capture),
    .rd_data    (rd_data)
  );

  // Access sequencer with registered BUSY, ACK and read data
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      cnt    <= 2'd0;
      addr_q <= 3'd0;
      mdr_q  <= '0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      mdr_q <= '0;
      case (state)
        ST_IDLE: begin
          if (rd_req) begin
            addr_q <= MA;
            busy_q <= 1'b1;
            if (NO_WAIT) begin
              state <= ST_RDATA;
              mdr_q <= rd_data;
              ack_q <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end else if (wr_req) begin
            state  <= ST_WACK;
            busy_q <= 1'b1;
            ack_q  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == 2'd0) begin
            state <= ST_RDATA;
            mdr_q <= rd_data;
            ack_q <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ST_RDATA: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        ST_WACK: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // The read leg is forced to zero outside RDATA so it never pollutes the OR bus
  always_comb begin
    MDR  = (state == ST_RDATA) ? mdr_q : 16'h0000;
    BUSY = busy_q;
    ACK  = ack_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_orbus_resp.sv
// ---------------------------------------------------------------------------
// tb_orbus_resp
// Self-checking bench for orbus_resp with three instances (WAIT_CYC 1, 0, 3).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_orbus_resp;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RD;
  logic        WR;
  logic [2:0]  csel;
  logic [2:0]  MA;
  logic [15:0] MDW;
  logic [1:0]  WBE;
  logic [15:0] EVT;
  logic [15:0] mdr [3];
  logic [2:0]  busy;
  logic [2:0]  ack;

  int cyc    = 0;
  int n_vec  = 0;
  int n_fail = 0;
  int lat [3] = '{2, 1, 4};

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    int          issue;
    int          lat;
  } exp_t;

  exp_t sb [3][$];

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  orbus_resp #(.WAIT_CYC(1)) dut_w1 (
    .CLK(CLK), .RESET(RESET), .CSEL(csel[0]), .RD(RD), .WR(WR), .MA(MA),
    .MDW(MDW), .WBE(WBE), .EVT(EVT), .MDR(mdr[0]), .BUSY(busy[0]), .ACK(ack[0]));

  orbus_resp #(.WAIT_CYC(0)) dut_w0 (
    .CLK(CLK), .RESET(RESET), .CSEL(csel[1]), .RD(RD), .WR(WR), .MA(MA),
    .MDW(MDW), .WBE(WBE), .EVT(EVT), .MDR(mdr[1]), .BUSY(busy[1]), .ACK(ack[1]));

  orbus_resp #(.WAIT_CYC(3), .ID_VAL(16'hBEEF)) dut_w3 (
    .CLK(CLK), .RESET(RESET), .CSEL(csel[2]), .RD(RD), .WR(WR), .MA(MA),
    .MDW(MDW), .WBE(WBE), .EVT(EVT), .MDR(mdr[2]), .BUSY(busy[2]), .ACK(ack[2]));

  // Monitor: pop an expectation on every ACK, otherwise MDR must be idle
  always @(negedge CLK) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (ack[k]) begin
        n_vec++;
        if (sb[k].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack dut%0d cycle %0d: got ACK, expected none", k, cyc);
        end else begin
          e = sb[k].pop_front();
          if (mdr[k] !== e.data || (cyc - e.issue) != e.lat) begin
            n_fail++;
            $display("FAIL %s dut%0d: got MDR=%h latency=%0d, expected MDR=%h latency=%0d",
                     e.is_rd ? "read" : "write_ack", k, mdr[k], cyc - e.issue, e.data, e.lat);
          end
        end
      end else begin
        n_vec++;
        if (mdr[k] !== 16'h0000) begin
          n_fail++;
          $display("FAIL mdr_idle dut%0d cycle %0d: got %h, expected 0000", k, cyc, mdr[k]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] === 1'b1) begin
      @(posedge CLK); #1;
      n++;
      if (n > 30) begin
        n_fail++;
        $display("FAIL busy_timeout dut%0d: got BUSY stuck, expected release within 30 cycles", k);
        break;
      end
    end
  endtask

  task automatic push(input int k, input bit is_rd, input logic [15:0] d);
    exp_t e;
    e.is_rd = is_rd;
    e.data  = d;
    e.issue = cyc;
    e.lat   = is_rd ? lat[k] : 1;
    sb[k].push_back(e);
  endtask

  task automatic do_wr(input int k, input logic [2:0] a, input logic [15:0] d,
                       input logic [1:0] be);
    wait_idle(k);
    csel[k] = 1'b1; WR = 1'b1; RD = 1'b0; MA = a; MDW = d; WBE = be;
    push(k, 1'b0, 16'h0000);
    @(posedge CLK); #1;
    csel[k] = 1'b0; WR = 1'b0;
  endtask

  // Read; optionally drive EVT during the cycle ending in the RDATA entry edge
  task automatic do_rd(input int k, input logic [2:0] a, input logic [15:0] exp,
                       input logic [15:0] evt_entry, input bit also_wr);
    wait_idle(k);
    csel[k] = 1'b1; RD = 1'b1; WR = also_wr; MA = a; MDW = 16'h0000; WBE = 2'b11;
    push(k, 1'b1, exp);
    @(posedge CLK); #1;
    csel[k] = 1'b0; RD = 1'b0; WR = 1'b0;
    if (evt_entry != 16'h0000) begin
      EVT = evt_entry;
      @(posedge CLK); #1;
      EVT = 16'h0000;
    end
  endtask

  task automatic pulse_evt(input logic [15:0] v);
    EVT = v;
    @(posedge CLK); #1;
    EVT = 16'h0000;
  endtask

  initial begin
    RESET = 1'b1; csel = 3'b000; RD = 1'b0; WR = 1'b0;
    MA = 3'd0; MDW = 16'h0000; WBE = 2'b00; EVT = 16'h0000;

    // Reset state, with events that must be ignored during reset
    repeat (2) @(posedge CLK);
    #1 EVT = 16'hFFFF;
    @(posedge CLK); #1 EVT = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      check("reset_mdr",  mdr[k],  16'h0000);
      check("reset_busy", busy[k], 16'h0000);
      check("reset_ack",  ack[k],  16'h0000);
    end
    @(posedge CLK); #1 RESET = 1'b0;
    @(posedge CLK); #1;

    do_rd(0, 3'd6, 16'h0000, 16'h0000, 1'b0);   // no events leaked through reset
    do_rd(0, 3'd2, 16'h0000, 16'h0000, 1'b0);

    // Full write then byte-lane write and an empty-enable write
    do_wr(0, 3'd2, 16'h1234, 2'b11);
    do_rd(0, 3'd2, 16'h1234, 16'h0000, 1'b0);
    do_wr(0, 3'd2, 16'hABCD, 2'b01);
    do_rd(0, 3'd2, 16'h12CD, 16'h0000, 1'b0);
    do_wr(0, 3'd2, 16'hFFFF, 2'b00);
    do_rd(0, 3'd2, 16'h12CD, 16'h0000, 1'b0);
    do_wr(0, 3'd2, 16'h5500, 2'b10);
    do_rd(0, 3'd2, 16'h55CD, 16'h0000, 1'b0);

    // Simultaneous RD&WR behaves as a read only
    do_wr(0, 3'd1, 16'h5A5A, 2'b11);
    do_rd(0, 3'd1, 16'h5A5A, 16'h0000, 1'b1);
    do_rd(0, 3'd1, 16'h5A5A, 16'h0000, 1'b0);

    // Write strobe held through WAIT and RDATA is ignored
    do_rd(0, 3'd3, 16'h0000, 16'h0000, 1'b0);
    csel[0] = 1'b1; WR = 1'b1; MA = 3'd3; MDW = 16'hFFFF; WBE = 2'b11;
    repeat (2) begin @(posedge CLK); #1; end
    csel[0] = 1'b0; WR = 1'b0;
    do_rd(0, 3'd3, 16'h0000, 16'h0000, 1'b0);

    // Strobe without chip select is ignored
    WR = 1'b1; MA = 3'd4; MDW = 16'h1111; WBE = 2'b11;
    repeat (2) begin @(posedge CLK); #1; end
    WR = 1'b0;
    do_rd(0, 3'd4, 16'h0000, 16'h0000, 1'b0);

    // Status and ID words ignore writes
    do_wr(0, 3'd6, 16'hFFFF, 2'b11);
    do_rd(0, 3'd6, 16'h0000, 16'h0000, 1'b0);
    do_wr(0, 3'd7, 16'h0000, 2'b11);
    do_rd(0, 3'd7, 16'h0A51, 16'h0000, 1'b0);

    // Sticky status with set-wins on the clearing edge
    pulse_evt(16'h0008);
    do_rd(0, 3'd6, 16'h0008, 16'h0008, 1'b0);
    do_rd(0, 3'd6, 16'h0008, 16'h0000, 1'b0);
    do_rd(0, 3'd6, 16'h0000, 16'h0000, 1'b0);
    pulse_evt(16'h8001);
    do_rd(0, 3'd6, 16'h8001, 16'h0000, 1'b0);
    do_rd(0, 3'd6, 16'h0000, 16'h0000, 1'b0);

    // Reset in WAIT aborts the read without ACK
    wait_idle(0);
    csel[0] = 1'b1; RD = 1'b1; MA = 3'd1;
    @(posedge CLK); #1;
    csel[0] = 1'b0; RD = 1'b0;
    check("busy_in_wait", busy[0], 16'h0001);
    RESET = 1'b1;
    #1;
    check("abort_busy", busy[0], 16'h0000);
    check("abort_mdr",  mdr[0],  16'h0000);
    check("abort_ack",  ack[0],  16'h0000);
    @(posedge CLK); #1 RESET = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    do_rd(0, 3'd7, 16'h0A51, 16'h0000, 1'b0);
    do_rd(0, 3'd1, 16'h0000, 16'h0000, 1'b0);

    // Zero wait states: latency 1
    do_wr(1, 3'd5, 16'h0F0F, 2'b11);
    do_rd(1, 3'd5, 16'h0F0F, 16'h0000, 1'b0);
    do_rd(1, 3'd7, 16'h0A51, 16'h0000, 1'b0);

    // Three wait states: latency 4
    do_wr(2, 3'd0, 16'hC3C3, 2'b11);
    do_wr(2, 3'd0, 16'h0000, 2'b10);
    do_rd(2, 3'd0, 16'h00C3, 16'h0000, 1'b0);
    do_rd(2, 3'd7, 16'hBEEF, 16'h0000, 1'b0);

    for (int k = 0; k < 3; k++) wait_idle(k);
    repeat (4) @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (sb[k].size() != 0) begin
        n_fail++;
        $display("FAIL missing_ack dut%0d: got %0d outstanding, expected 0", k, sb[k].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/orbus_resp.md
ORBUS_RESP -- requirements
Module: orbus_resp

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 1, read wait states inserted before read data is driven (legal 0..3).
REQ-002 SHALL have parameter ID_VAL, default 16'h0A51, constant returned at address 7.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port CSEL  input  1  this responder's address window is selected.
REQ-006 SHALL have port RD  input  1  read strobe, qualified by CSEL.
REQ-007 SHALL have port WR  input  1  write strobe, qualified by CSEL.
REQ-008 SHALL have port MA  input  3  word address within window.
REQ-009 SHALL have port MDW  input  16  write data.
REQ-010 SHALL have port WBE  input  2  byte enables; bit1 = [15:8], bit0 = [7:0].
REQ-011 SHALL have port EVT  input  16  hardware event pulses feeding the status register.
REQ-012 SHALL have port MDR  output  16  read data leg for the OR-combined read bus; all-zero except when driving.
REQ-013 SHALL have port BUSY  output  1  access in progress; new strobes ignored.
REQ-014 SHALL have port ACK  output  1  one-cycle completion pulse for read or write.

Function
REQ-015 SHALL implement states IDLE, WAIT, RDATA, WACK; only IDLE accepts strobes.
REQ-016 In IDLE with CSEL&RD, SHALL go to WAIT loading counter with WAIT_CYC-1, or directly to RDATA when WAIT_CYC=0.
REQ-017 In WAIT, counter SHALL decrement each cycle; at zero, next state RDATA.
REQ-018 Read data SHALL be captured on the edge entering RDATA; MDR SHALL equal captured data and ACK=1 for exactly the one RDATA cycle, then IDLE.
REQ-019 Read latency from strobe cycle to MDR valid SHALL be WAIT_CYC+1 cycles.
REQ-020 MDR SHALL be 16'h0000 in every state except RDATA, so it never corrupts the OR bus.
REQ-021 In IDLE with CSEL&WR&~RD, SHALL update addressed register bytes per WBE on that edge, then WACK (ACK=1, one cycle), then IDLE.
REQ-022 CSEL&RD&WR together SHALL be treated as a read; write dropped.
REQ-023 Strobes without CSEL, or any strobe while BUSY, SHALL be ignored with no state change.
REQ-024 BUSY SHALL be 1 in WAIT, RDATA, WACK; 0 in IDLE.
REQ-025 Addresses 0..5 SHALL be 16-bit read/write registers.
REQ-026 Address 6 SHALL be sticky status: bit n set when EVT[n]=1; read-to-clear of exactly the bits captured on the RDATA entry edge; writes ignored.
REQ-027 On simultaneous EVT set and read-clear of the same bit, set SHALL win (bit remains 1).
REQ-028 Address 7 SHALL read ID_VAL; writes ignored.
REQ-029 WBE=2'b00 write SHALL complete with ACK but change no register.

Reset
REQ-030 RESET SHALL asynchronously force state IDLE, counter 0, MDR=0, BUSY=0, ACK=0, registers 0..5 and status = 16'h0000.
REQ-031 RESET asserted mid-access SHALL abort it with no ACK and no register update; status clear of an aborted read SHALL not occur.
REQ-032 EVT SHALL be ignored while RESET is high.

Structure
REQ-033 State encodings, register address constants (REG_STAT=6, REG_ID=7) SHALL live in a shared orbus package/include.
REQ-034 Register file and status logic SHALL be sub-module orbus_resp_regs; FSM, counter and MDR gating in top.

Verification
REQ-035 WAIT_CYC=1: write 16'h1234 to addr 2, WBE=11 -> ACK next cycle; read addr 2 -> MDR=16'h1234 two cycles after strobe, MDR=0 all other cycles.
REQ-036 WBE=01 write 16'hABCD to addr 2 holding 16'h1234 -> read returns 16'h12CD.
REQ-037 EVT[3] pulse, then read addr 6 with EVT[3] re-pulsed on RDATA entry edge -> MDR=16'h0008, bit 3 still set; second read returns 16'h0008 then 16'h0000.
REQ-038 RD&WR to addr 1 -> read returns prior value, addr 1 unchanged; strobe during BUSY -> no extra ACK.
REQ-039 RESET asserted in WAIT -> no ACK, MDR=0, BUSY=0; read addr 7 after -> 16'h0A51.
REQ-040 WAIT_CYC=0 and 3 -> read latency 1 and 4 cycles respectively.
